// File: rtl/serial_bcd_alu_n.sv
// Digit-serial BCD add/subtract unit, DIGITS digits per operand.
// Framed serial input, signed-magnitude serial output with valid strobe.
module serial_bcd_alu_n #(
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in,
  output logic result,
  output logic out_valid,
  output logic busy,
  output logic err
);

  localparam int N_IN  = 1 + 8 * DIGITS;
  localparam int N_OUT = 1 + 4 * (DIGITS + 1);
  localparam int SW    = 4 * DIGITS;

  typedef enum logic [2:0] {
    IDLE, LOAD, CALC, FIX, SHIFT
  } state_t;

  state_t state, state_n;

  logic [N_IN-1:0]  frame;
  logic [N_OUT-1:0] res;
  logic [6:0]       cnt;
  logic             carry;
  logic             err_q;

  logic       op, bad, full, last_d, last_s;
  logic [3:0] a_d, b_d, opd, c_dig, f_dig;
  logic [4:0] c_sum, f_sum;
  logic       c_cy, f_cy;

  assign op     = frame[N_IN-1];
  assign a_d    = frame[SW+3:SW];
  assign b_d    = frame[3:0];
  assign full   = cnt == 7'(N_IN);
  assign last_d = cnt == 7'(DIGITS - 1);
  assign last_s = cnt == 7'(N_OUT - 1);

  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < 2 * DIGITS; k++)
      if (frame[4*k +: 4] > 4'd9) bad = 1'b1;
  end

  // Subtract adds the nines' complement of B with carry-in 1.
  always_comb begin
    opd   = op ? 4'd9 - b_d : b_d;
    c_sum = {1'b0, a_d} + {1'b0, opd} + {4'b0, carry};
    c_cy  = c_sum > 5'd9;
    c_dig = c_cy ? 4'(c_sum - 5'd10) : c_sum[3:0];
    f_sum = 5'd9 - {1'b0, res[3:0]} + {4'b0, carry};
    f_cy  = f_sum > 5'd9;
    f_dig = f_cy ? 4'(f_sum - 5'd10) : f_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (en) state_n = LOAD;
      LOAD:  if (!en) state_n = full ? CALC : IDLE;
      CALC: begin
        if (bad)
          state_n = IDLE;
        else if (last_d)
          state_n = (op && !c_cy) ? FIX : SHIFT;
      end
      FIX:   if (last_d) state_n = SHIFT;
      SHIFT: if (last_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = state == CALC || state == FIX ||
                state == SHIFT;
    out_valid = state == SHIFT;
    result    = out_valid & res[N_OUT-1];
    err       = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            frame <= {frame[N_IN-2:0], in};
            cnt   <= 7'd1;
          end
        end
        LOAD: begin
          if (en) begin
            if (!full) begin
              frame <= {frame[N_IN-2:0], in};
              cnt   <= cnt + 7'd1;
            end
          end else begin
            cnt <= '0;
            if (!full || bad) err_q <= 1'b1;
            if (full) carry <= op;
          end
        end
        CALC: begin
          if (bad) begin
            cnt <= '0;
          end else begin
            res[SW-1:0] <= SW'({c_dig, res[SW-1:0]} >> 4);
            frame <= {frame[N_IN-1:2*SW],
                      frame[2*SW-1:SW] >> 4,
                      frame[SW-1:0] >> 4};
            carry <= c_cy;
            cnt   <= cnt + 7'd1;
            if (last_d) begin
              cnt              <= '0;
              res[N_OUT-1]     <= op & ~c_cy;
              res[SW+3:SW]     <= {3'b0, ~op & c_cy};
              if (op) carry    <= 1'b1;
            end
          end
        end
        FIX: begin
          res[SW-1:0] <= SW'({f_dig, res[SW-1:0]} >> 4);
          carry <= f_cy;
          cnt   <= last_d ? 7'd0 : cnt + 7'd1;
        end
        SHIFT: begin
          res <= {res[N_OUT-2:0], 1'b0};
          cnt <= last_s ? 7'd0 : cnt + 7'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bcd_alu_n.sv
// Directed bench for serial_bcd_alu_n (DIGITS=4 and DIGITS=1).
// Each scenario task drives a frame and checks the serial result.
module tb_serial_bcd_alu_n;

  logic clk = 1'b0;
  logic rst, en, in, en1, in1;
  logic result, out_valid, busy, err;
  logic result1, ov1, busy1, err1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_bcd_alu_n #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .result(result), .out_valid(out_valid),
    .busy(busy), .err(err)
  );

  serial_bcd_alu_n #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .in(in1),
    .result(result1), .out_valid(ov1),
    .busy(busy1), .err(err1)
  );

  task automatic drive(input bit sel, input logic e,
                       input logic b);
    if (sel) begin en1 = e; in1 = b; end
    else     begin en  = e; in  = b; end
  endtask

  // Holds en for 'hold' cycles; bits past flen are 1s.
  task automatic send(input bit sel, input logic [32:0] f,
                      input int flen, input int hold);
    logic b;
    for (int k = 0; k < hold; k++) begin
      b = (k < flen) ? f[flen-1-k] : 1'b1;
      drive(sel, 1'b1, b);
      @(negedge clk);
    end
    drive(sel, 1'b0, 1'b0);
  endtask

  task automatic collect(input bit sel, input int pulse_at,
                         output logic [36:0] got,
                         output int lat, output int n,
                         output int errs, output logic bsy);
    logic v, r;
    got = '0; lat = -1; n = 0; errs = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      v = sel ? ov1 : out_valid;
      r = sel ? result1 : result;
      if (sel ? err1 : err) errs++;
      if (pulse_at > 0 && c == pulse_at)
        drive(sel, 1'b1, 1'b1);
      if (pulse_at > 0 && c == pulse_at + 2)
        drive(sel, 1'b0, 1'b0);
      if (v) begin
        if (lat < 0) lat = c;
        got = {got[35:0], r};
        n++;
      end else if (lat >= 0) begin
        break;
      end
    end
    bsy = sel ? busy1 : busy;
  endtask

  logic [36:0] got;
  int lat, n, errs;
  logic bsy;

  task automatic test_reset;
    rst = 1'b1; en = 0; in = 0; en1 = 0; in1 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({result, out_valid, busy, err} !== 4'b0) begin
      failures++;
      $display("FAIL reset4 got=%b want=0000",
               {result, out_valid, busy, err});
    end
    checks++;
    if ({result1, ov1, busy1, err1} !== 4'b0) begin
      failures++;
      $display("FAIL reset1 got=%b want=0000",
               {result1, ov1, busy1, err1});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    send(0, {1'b0, 16'h1234, 16'h5678}, 33, 33);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (got[20:0] !== 21'h006912 || n != 21) begin
      failures++;
      $display("FAIL add val=%h n=%0d want 006912 n=21",
               got[20:0], n);
    end
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL add_lat got=%0d want=5", lat);
    end
    checks++;
    if (bsy !== 1'b0 || errs != 0) begin
      failures++;
      $display("FAIL add_idle busy=%b errs=%0d want 0/0",
               bsy, errs);
    end
  endtask

  task automatic test_sub_pos;
    send(0, {1'b1, 16'h5678, 16'h1234}, 33, 33);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (got[20:0] !== 21'h004444 || n != 21) begin
      failures++;
      $display("FAIL sub_pos val=%h n=%0d want 004444",
               got[20:0], n);
    end
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL sub_pos_lat got=%0d want=5", lat);
    end
  endtask

  task automatic test_sub_neg;
    send(0, {1'b1, 16'h1234, 16'h5678}, 33, 33);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (got[20:0] !== 21'h104444 || n != 21) begin
      failures++;
      $display("FAIL sub_neg val=%h n=%0d want 104444",
               got[20:0], n);
    end
    checks++;
    if (lat != 9 || bsy !== 1'b0) begin
      failures++;
      $display("FAIL sub_neg_lat got=%0d busy=%b want=9/0",
               lat, bsy);
    end
  endtask

  task automatic test_sub_zero;
    send(0, {1'b1, 16'h0042, 16'h0042}, 33, 33);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (got[20:0] !== 21'h000000 || lat != 5) begin
      failures++;
      $display("FAIL sub_zero val=%h lat=%0d want 000000/5",
               got[20:0], lat);
    end
  endtask

  task automatic test_add_max;
    send(0, {1'b0, 16'h9999, 16'h9999}, 33, 33);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (got[20:0] !== 21'h019998 || n != 21) begin
      failures++;
      $display("FAIL add_max val=%h n=%0d want 019998",
               got[20:0], n);
    end
  endtask

  task automatic test_digits1;
    send(1, 33'({1'b0, 4'h7, 4'h5}), 9, 9);
    collect(1, 0, got, lat, n, errs, bsy);
    checks++;
    if (got[8:0] !== 9'h012 || n != 9) begin
      failures++;
      $display("FAIL d1 val=%h n=%0d want 012 n=9",
               got[8:0], n);
    end
    checks++;
    if (lat != 2 || bsy !== 1'b0) begin
      failures++;
      $display("FAIL d1_lat got=%0d busy=%b want=2/0",
               lat, bsy);
    end
  endtask

  task automatic test_bad_digit;
    send(0, {1'b0, 16'h12A4, 16'h5678}, 33, 33);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (errs != 1 || lat != -1) begin
      failures++;
      $display("FAIL bad_digit errs=%0d lat=%0d want 1/-1",
               errs, lat);
    end
    checks++;
    if (bsy !== 1'b0) begin
      failures++;
      $display("FAIL bad_digit_busy got=%b want=0", bsy);
    end
  endtask

  task automatic test_short_frame;
    send(0, {1'b0, 16'h1234, 16'h5678}, 33, 20);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (errs != 1 || lat != -1) begin
      failures++;
      $display("FAIL short errs=%0d lat=%0d want 1/-1",
               errs, lat);
    end
    send(0, {1'b0, 16'h0500, 16'h0505}, 33, 33);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (got[20:0] !== 21'h001005 || errs != 0) begin
      failures++;
      $display("FAIL short_next val=%h errs=%0d want 001005",
               got[20:0], errs);
    end
  endtask

  task automatic test_long_frame;
    send(0, {1'b0, 16'h1234, 16'h5678}, 33, 40);
    collect(0, 0, got, lat, n, errs, bsy);
    checks++;
    if (got[20:0] !== 21'h006912 || errs != 0) begin
      failures++;
      $display("FAIL long val=%h errs=%0d want 006912",
               got[20:0], errs);
    end
  endtask

  task automatic test_en_in_calc;
    send(0, {1'b1, 16'h1234, 16'h5678}, 33, 33);
    collect(0, 2, got, lat, n, errs, bsy);
    checks++;
    if (got[20:0] !== 21'h104444 || lat != 9 ||
        errs != 0) begin
      failures++;
      $display("FAIL en_calc val=%h lat=%0d errs=%0d",
               got[20:0], lat, errs);
    end
  endtask

  task automatic test_rst_mid_shift;
    int c;
    int seen;
    send(0, {1'b0, 16'h1234, 16'h5678}, 33, 33);
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre out_valid=%b want=1", out_valid);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({result, out_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid got=%b want=000",
               {result, out_valid, busy});
    end
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_after valid_cycles=%0d want=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_pos();
    test_sub_neg();
    test_sub_zero();
    test_add_max();
    test_digits1();
    test_bad_digit();
    test_short_frame();
    test_long_frame();
    test_en_in_calc();
    test_rst_mid_shift();
    test_add();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_bcd_alu_n.md
Name: serial_bcd_alu_n

Overview:
- Parametrised serial BCD add/subtract unit. Successor to the fixed 4-digit serial BCD ALU.
- Shifts in one framed bitstream carrying the opcode and operands A and B (DIGITS BCD digits each).
- Computes digit-serially, one digit per clock, with a correct signed-magnitude subtraction result.
- Shifts the signed result out serially with a valid strobe. Flags malformed frames and non-BCD digits.

Parameters:
- DIGITS, 4, BCD digits per operand; legal range 1..8.
- N_IN, 1+8*DIGITS, derived: input frame length in bits.
- N_OUT, 1+4*(DIGITS+1), derived: output frame length in bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  input frame strobe; high while frame bits are presented.
- in  in  1  serial input bit, sampled when en=1.
- result  out  1  serial output bit; 0 when out_valid=0.
- out_valid  out  1  high for exactly N_OUT consecutive cycles while result bits are driven.
- busy  out  1  high in CALC, FIX and SHIFT; en is ignored while busy=1.
- err  out  1  one-cycle pulse on frame or digit error.

Behaviour:
- Reset: one clock, synchronous, active-high; `rst` sampled high clears everything.
  - State goes to IDLE; bit counter, shift registers and carry clear to 0.
  - result=0, out_valid=0, busy=0, err=0.
  - rst has priority over all events, including mid-frame, mid-calc and mid-shift; any partial frame or output is discarded.
- Input frame, MSB-first:
  - bit 0: op (0=add, 1=subtract A-B);
  - next 4*DIGITS bits: A, most significant digit first, each digit MSB-first;
  - next 4*DIGITS bits: B, same order.
- States: IDLE, LOAD, CALC, FIX, SHIFT.
- IDLE:
  - en=1: capture bit, count=1, go to LOAD.
- LOAD:
  - Each en=1 cycle: capture bit, count+1.
  - Bits beyond N_IN are ignored and count saturates.
  - en=0 with count=N_IN: go to CALC.
  - en=0 with count<N_IN: err pulse next cycle, discard frame, go to IDLE.
- CALC entry, digit check:
  - Any A or B digit >9 gives an err pulse in the first CALC cycle, then IDLE with no output.
- CALC: DIGITS cycles, digit i=0 (LS) .. DIGITS-1, one digit per cycle.
  - Carry register starts at op.
  - Operand digit is B[i] for add, 9-B[i] for subtract.
  - s = A[i] + operand + carry. If s>9, store s-10 and set carry=1; otherwise store s and set carry=0.
- End of CALC:
  - add: top digit = carry (0 or 1), sign=0, go to SHIFT.
  - subtract with carry=1: top digit=0, sign=0, go to SHIFT.
  - subtract with carry=0: sign=1, go to FIX.
- FIX: DIGITS cycles replacing S with the ten's complement of S.
  - Digit-serial: 9-S[i]+carry, with carry starting at 1.
  - Top digit=0; then go to SHIFT.
- SHIFT: N_OUT cycles.
  - Output order: sign, then the DIGITS+1 result digits, most significant digit first, each digit MSB-first.
  - out_valid=1 throughout; the first bit comes on the cycle after the last CALC/FIX cycle.
  - After the last bit: out_valid=0, go to IDLE. A new frame may start that same next cycle.
- Latency from the en-falling sample to the first output bit: DIGITS+1 cycles for add or non-negative subtract; 2*DIGITS+1 cycles for negative subtract.
- Zero results: A-B=0 gives sign=0 and all digits 0; -0 is never produced.
- busy=1 from the first CALC cycle through the last SHIFT cycle. en=1 during busy is ignored; no err.

Test Plan:
- DIGITS=4, frame op=0, A=1234, B=5678 -> after 5 cycles, 21 bits with out_valid: sign 0, digits 0,6,9,1,2 (06912). busy low after.
- op=1, A=5678, B=1234 -> first bit 5 cycles after en falls; sign 0, digits 04444.
- op=1, A=1234, B=5678 -> first bit 9 cycles after en falls (FIX taken); sign 1, digits 04444. op=1, A=B=0042 -> sign 0, 00000.
- op=0, A=9999, B=9999 -> 19998. DIGITS=1 build: op=0, A=7, B=5 -> N_OUT=9, sign 0, digits 1,2.
- Error cases:
  - A digit 1010 in an otherwise valid frame -> err single-cycle pulse, out_valid never asserts, IDLE.
  - en dropped after 20 bits -> err pulse, then a correct next frame processes normally.
  - en held 40 cycles -> extra bits ignored, result from the first 33 bits.
- rst high for one cycle mid-SHIFT (bit 10) -> next cycle result=0, out_valid=0, busy=0. en pulsed during CALC -> ignored, result unchanged.
